// File: rtl/colordetc_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : colordetc_seq_if
// Description : Key/frame-sync inputs and color-select outputs of the
//               color-detector sequencer, grouped as one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface colordetc_seq_if;
  logic [3:0] key_n;    // raw active-low buttons: [3]=red [2]=green [1]=blue [0]=pass
  logic       vsync;    // frame sync, active-high level
  logic       auto_en;  // auto-cycle enable
  logic [3:0] clr_sel;  // one-hot, one-cycle select pulse
  logic [1:0] mode;     // applied mode code
  logic       pending;  // manual request waiting for a frame boundary

  // Stimulus side
  modport master (
    output key_n, vsync, auto_en,
    input  clr_sel, mode, pending
  );

  // Sequencer side
  modport slave (
    input  key_n, vsync, auto_en,
    output clr_sel, mode, pending
  );
endinterface
`default_nettype wire

// File: rtl/colordetc_seq.sv
`default_nettype none
// ============================================================================
// Module      : colordetc_seq
// Description : Debounces four color keys and issues one-hot select pulses
//               to a color detector, aligned to frame boundaries, with an
//               optional auto-cycle mode (red -> green -> blue -> red).
// Revision    : 1.0 - initial release
// ============================================================================
module colordetc_seq #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int AUTO_FRAMES  = 60
) (
  input  wire logic       clk,
  input  wire logic       rst,
  colordetc_seq_if.slave  bus
);

  localparam logic [15:0] c_DEB_LAST    = 16'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]  c_AUTO_FRAMES = 8'(AUTO_FRAMES);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ARMED = 2'd1;
  localparam logic [1:0] c_ST_ISSUE = 2'd2;

  localparam logic [1:0] c_CODE_RED   = 2'b01;
  localparam logic [1:0] c_CODE_GREEN = 2'b00;
  localparam logic [1:0] c_CODE_BLUE  = 2'b10;
  localparam logic [1:0] c_CODE_PASS  = 2'b11;

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d;
  logic [3:0][15:0] cnt_q, cnt_d;
  logic             vsync_q;
  logic [1:0]       state_q, state_d;
  logic [1:0]       req_q, req_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       frame_q, frame_d;

  logic [3:0] w_press;
  logic       w_press_any;
  logic [1:0] w_press_code;
  logic       w_boundary;
  logic [7:0] w_frame_inc;
  logic [1:0] w_next_code;
  logic [3:0] w_clr_sel;
  logic       w_pending;

  // Two-flop synchronizer for the asynchronous key inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= bus.key_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing cycles;
  // a press is the accepted 1->0 change, so the event fires as the level flips
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    w_press = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == c_DEB_LAST) begin
          deb_d[i]   = sync2_q[i];
          w_press[i] = deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Debounce and frame-sync history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q   <= 4'hF;
      cnt_q   <= '0;
      vsync_q <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      vsync_q <= bus.vsync;
    end
  end

  // Priority encode simultaneous presses, find the boundary and the auto-cycle successor
  always_comb begin
    w_press_any  = |w_press;
    w_press_code = c_CODE_PASS;
    if (w_press[3])      w_press_code = c_CODE_RED;
    else if (w_press[2]) w_press_code = c_CODE_GREEN;
    else if (w_press[1]) w_press_code = c_CODE_BLUE;
    w_boundary  = bus.vsync & ~vsync_q;
    w_frame_inc = frame_q + 8'd1;
    case (mode_q)
      c_CODE_RED:   w_next_code = c_CODE_GREEN;
      c_CODE_GREEN: w_next_code = c_CODE_BLUE;
      default:      w_next_code = c_CODE_RED;
    endcase
  end

  // FSM state register; mode is loaded on entry to ISSUE so it changes with the pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_IDLE;
      req_q   <= c_CODE_PASS;
      mode_q  <= c_CODE_PASS;
      frame_q <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      mode_q  <= mode_d;
      frame_q <= frame_d;
    end
  end

  // FSM next-state: manual requests wait for a boundary, auto advance only from IDLE
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    mode_d  = mode_q;
    frame_d = frame_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_press_any) begin
          state_d = c_ST_ARMED;
          req_d   = w_press_code;
        end else if (bus.auto_en && w_boundary) begin
          if (w_frame_inc == c_AUTO_FRAMES) begin
            state_d = c_ST_ISSUE;
            mode_d  = w_next_code;
            frame_d = 8'd0;
          end else begin
            frame_d = w_frame_inc;
          end
        end
      end
      c_ST_ARMED: begin
        // A press coinciding with the boundary is dropped in favour of the held request
        if (w_boundary) begin
          state_d = c_ST_ISSUE;
          mode_d  = req_q;
        end else if (w_press_any) begin
          req_d = w_press_code;
        end
      end
      c_ST_ISSUE: begin
        frame_d = 8'd0;
        if (w_press_any) begin
          state_d = c_ST_ARMED;
          req_d   = w_press_code;
        end else begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
    if (!bus.auto_en) frame_d = 8'd0;
  end

  // FSM outputs: one-hot select only during ISSUE, pending only in ARMED
  always_comb begin
    w_clr_sel = 4'b0000;
    if (state_q == c_ST_ISSUE) begin
      case (mode_q)
        c_CODE_RED:   w_clr_sel = 4'b1000;
        c_CODE_GREEN: w_clr_sel = 4'b0100;
        c_CODE_BLUE:  w_clr_sel = 4'b0010;
        default:      w_clr_sel = 4'b0001;
      endcase
    end
    w_pending = (state_q == c_ST_ARMED);
  end

  assign bus.clr_sel = w_clr_sel;
  assign bus.mode    = mode_q;
  assign bus.pending = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_colordetc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_colordetc_seq
// Description : Directed self-checking bench for colordetc_seq
//               (DEBOUNCE_CYC=4, AUTO_FRAMES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_colordetc_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;
  int   base;

  colordetc_seq_if bus_if ();

  colordetc_seq #(.DEBOUNCE_CYC(4), .AUTO_FRAMES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Count clk cycles in which a select pulse is visible
  always @(negedge clk) if (bus_if.clr_sel != 4'b0000) pulse_cnt++;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.key_n   = 4'hF;
    bus_if.vsync   = 1'b0;
    bus_if.auto_en = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_if.mode !== 2'b11) begin errors++; $display("FAIL reset_mode got %b exp 11", bus_if.mode); end
    checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", bus_if.pending); end
    checks++; if (bus_if.clr_sel !== 4'b0000) begin errors++; $display("FAIL reset_clr_sel got %b exp 0000", bus_if.clr_sel); end
  endtask

  task automatic test_red_press();
    do_reset();
    base = pulse_cnt;
    bus_if.key_n = 4'b0111;
    tick(5);
    checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL red_pending_early got %b exp 0", bus_if.pending); end
    tick(1);
    checks++; if (bus_if.pending !== 1'b1) begin errors++; $display("FAIL red_pending_at6 got %b exp 1", bus_if.pending); end
    tick(4);
    bus_if.key_n = 4'hF;
    tick(2);
    checks++; if (pulse_cnt - base !== 0) begin errors++; $display("FAIL red_no_early_pulse got %0d exp 0", pulse_cnt - base); end
    bus_if.vsync = 1'b1;
    tick(1);
    checks++; if (bus_if.clr_sel !== 4'b1000) begin errors++; $display("FAIL red_clr_sel got %b exp 1000", bus_if.clr_sel); end
    checks++; if (bus_if.mode !== 2'b01) begin errors++; $display("FAIL red_mode got %b exp 01", bus_if.mode); end
    checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL red_pending_after got %b exp 0", bus_if.pending); end
    bus_if.vsync = 1'b0;
    tick(1);
    checks++; if (bus_if.clr_sel !== 4'b0000) begin errors++; $display("FAIL red_pulse_width got %b exp 0000", bus_if.clr_sel); end
    tick(6);
  endtask

  task automatic test_glitch();
    base = pulse_cnt;
    bus_if.key_n = 4'b1011;
    tick(3);
    bus_if.key_n = 4'hF;
    tick(10);
    checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL glitch_pending got %b exp 0", bus_if.pending); end
    bus_if.vsync = 1'b1;
    tick(1);
    bus_if.vsync = 1'b0;
    tick(2);
    checks++; if (pulse_cnt - base !== 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", pulse_cnt - base); end
    checks++; if (bus_if.mode !== 2'b01) begin errors++; $display("FAIL glitch_mode got %b exp 01", bus_if.mode); end
  endtask

  task automatic test_last_wins();
    base = pulse_cnt;
    bus_if.key_n = 4'b1101;
    tick(8);
    bus_if.key_n = 4'hF;
    tick(2);
    checks++; if (bus_if.pending !== 1'b1) begin errors++; $display("FAIL lastwins_pending got %b exp 1", bus_if.pending); end
    bus_if.key_n = 4'b1110;
    tick(8);
    bus_if.key_n = 4'hF;
    tick(8);
    bus_if.vsync = 1'b1;
    tick(1);
    checks++; if (bus_if.clr_sel !== 4'b0001) begin errors++; $display("FAIL lastwins_clr_sel got %b exp 0001", bus_if.clr_sel); end
    checks++; if (bus_if.mode !== 2'b11) begin errors++; $display("FAIL lastwins_mode got %b exp 11", bus_if.mode); end
    bus_if.vsync = 1'b0;
    tick(3);
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL lastwins_pulses got %0d exp 1", pulse_cnt - base); end
    checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL lastwins_pending_after got %b exp 0", bus_if.pending); end
  endtask

  task automatic test_auto();
    logic [3:0] exp_sel;
    do_reset();
    base = pulse_cnt;
    bus_if.auto_en = 1'b1;
    tick(1);
    for (int f = 1; f <= 7; f++) begin
      exp_sel = (f == 3) ? 4'b1000 : (f == 6) ? 4'b0100 : 4'b0000;
      bus_if.vsync = 1'b1;
      tick(1);
      checks++; if (bus_if.clr_sel !== exp_sel) begin errors++; $display("FAIL auto_frame%0d_clr_sel got %b exp %b", f, bus_if.clr_sel, exp_sel); end
      if (f == 3) begin
        checks++; if (bus_if.mode !== 2'b01) begin errors++; $display("FAIL auto_mode_f3 got %b exp 01", bus_if.mode); end
      end
      if (f == 6) begin
        checks++; if (bus_if.mode !== 2'b00) begin errors++; $display("FAIL auto_mode_f6 got %b exp 00", bus_if.mode); end
      end
      bus_if.vsync = 1'b0;
      tick(3);
    end
    checks++; if (pulse_cnt - base !== 2) begin errors++; $display("FAIL auto_pulses got %0d exp 2", pulse_cnt - base); end
    checks++; if (bus_if.mode !== 2'b00) begin errors++; $display("FAIL auto_mode_end got %b exp 00", bus_if.mode); end
    bus_if.auto_en = 1'b0;
  endtask

  task automatic test_press_at_boundary();
    do_reset();
    base = pulse_cnt;
    bus_if.key_n = 4'b1011;
    tick(5);
    bus_if.vsync = 1'b1;
    tick(1);
    checks++; if (bus_if.clr_sel !== 4'b0000) begin errors++; $display("FAIL pab_clr_sel got %b exp 0000", bus_if.clr_sel); end
    checks++; if (bus_if.pending !== 1'b1) begin errors++; $display("FAIL pab_pending got %b exp 1", bus_if.pending); end
    bus_if.vsync = 1'b0;
    bus_if.key_n = 4'hF;
    tick(8);
    bus_if.vsync = 1'b1;
    tick(1);
    checks++; if (bus_if.clr_sel !== 4'b0100) begin errors++; $display("FAIL pab_next_clr_sel got %b exp 0100", bus_if.clr_sel); end
    checks++; if (bus_if.mode !== 2'b00) begin errors++; $display("FAIL pab_mode got %b exp 00", bus_if.mode); end
    bus_if.vsync = 1'b0;
    tick(2);
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL pab_pulses got %0d exp 1", pulse_cnt - base); end
  endtask

  task automatic test_armed_drop();
    do_reset();
    bus_if.key_n = 4'b1101;
    tick(8);
    bus_if.key_n = 4'hF;
    tick(8);
    bus_if.key_n = 4'b0111;
    tick(5);
    bus_if.vsync = 1'b1;
    tick(1);
    checks++; if (bus_if.clr_sel !== 4'b0010) begin errors++; $display("FAIL drop_clr_sel got %b exp 0010", bus_if.clr_sel); end
    checks++; if (bus_if.mode !== 2'b10) begin errors++; $display("FAIL drop_mode got %b exp 10", bus_if.mode); end
    bus_if.vsync = 1'b0;
    tick(1);
    checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL drop_pending got %b exp 0", bus_if.pending); end
    bus_if.key_n = 4'hF;
    tick(8);
  endtask

  task automatic test_reset_mid();
    do_reset();
    base = pulse_cnt;
    bus_if.key_n = 4'b0111;
    tick(8);
    bus_if.key_n = 4'hF;
    tick(1);
    checks++; if (bus_if.pending !== 1'b1) begin errors++; $display("FAIL rstmid_armed got %b exp 1", bus_if.pending); end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    bus_if.vsync = 1'b1;
    tick(1);
    checks++; if (bus_if.clr_sel !== 4'b0000) begin errors++; $display("FAIL rstmid_clr_sel got %b exp 0000", bus_if.clr_sel); end
    checks++; if (bus_if.mode !== 2'b11) begin errors++; $display("FAIL rstmid_mode got %b exp 11", bus_if.mode); end
    checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending got %b exp 0", bus_if.pending); end
    bus_if.vsync = 1'b0;
    tick(2);
    checks++; if (pulse_cnt - base !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d exp 0", pulse_cnt - base); end
  endtask

  initial begin
    bus_if.key_n   = 4'hF;
    bus_if.vsync   = 1'b0;
    bus_if.auto_en = 1'b0;
    test_reset();
    test_red_press();
    test_glitch();
    test_last_wins();
    test_auto();
    test_press_at_boundary();
    test_armed_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/colordetc_seq.md
COLORDETC_SEQ -- requirements
Module: colordetc_seq

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 16: consecutive stable cycles needed to accept a key level change; legal range 2..65535.
REQ-002 The block SHALL have parameter AUTO_FRAMES, default 60: frames per step in auto-cycle mode; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port key_n, input, 4 bits: raw active-low push buttons, asynchronous. Mapping: [3]=red, [2]=green, [1]=blue, [0]=pass-through.
REQ-006 The block SHALL have port vsync, input, 1 bit: frame sync, synchronous to clk, active-high level.
REQ-007 The block SHALL have port auto_en, input, 1 bit: enables auto-cycle mode; clk-synchronous.
REQ-008 The block SHALL have port clr_sel, output, 4 bits: one-hot, one-cycle pulse to the color detector's select input.
REQ-009 The block SHALL have port mode, output, 2 bits: current applied mode code. 01=red, 00=green, 10=blue, 11=pass.
REQ-010 The block SHALL have port pending, output, 1 bit: high while a manual request awaits a frame boundary.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each key SHALL keep a debounced level (reset 1) and a cycle counter; the counter clears whenever the synchronized level equals the debounced level.
REQ-013 The debounced level SHALL take the synchronized value once the two have differed for DEBOUNCE_CYC consecutive cycles; the counter then clears.
REQ-014 A press event SHALL be a debounced 1->0 transition; release events SHALL be ignored.
REQ-015 Simultaneous press events SHALL resolve by priority [3]>[2]>[1]>[0].
REQ-016 A frame boundary SHALL be vsync=1 while the previous-cycle registered vsync=0; vsync_d resets to 0.
REQ-017 The FSM SHALL have states IDLE, ARMED and ISSUE, and SHALL reset to IDLE.
REQ-018 IDLE + press -> ARMED, storing the requested code in req_reg.
REQ-019 ARMED + further press -> stay ARMED and overwrite req_reg (last request wins).
REQ-020 ARMED + frame boundary -> ISSUE. A press in the same cycle as the boundary SHALL be dropped; req_reg as held before that cycle is issued.
REQ-021 In ISSUE (exactly one cycle): clr_sel SHALL be the one-hot for the code being applied, mode SHALL be updated in the same cycle, and the frame counter SHALL clear.
REQ-022 ISSUE SHALL exit to ARMED if a press occurs during ISSUE, else to IDLE.
REQ-023 pending SHALL be high exactly in ARMED; clr_sel SHALL be 0000 outside ISSUE.
REQ-024 Auto mode: in IDLE with auto_en=1, each frame boundary SHALL increment an 8-bit frame counter.
REQ-025 When an incremented count would reach AUTO_FRAMES, the FSM SHALL go to ISSUE with the next code in sequence red -> green -> blue -> red; from pass (11) the next code is red.
REQ-026 With auto_en=0 the frame counter SHALL hold at 0 and auto advance SHALL never occur.
REQ-027 In ARMED, manual requests SHALL take precedence over auto advance; the frame counter holds in ARMED.
REQ-028 Latency SHALL be as follows: boundary detected in cycle t -> clr_sel pulse in cycle t+1. key_n fall -> press event after 2+DEBOUNCE_CYC cycles.

Reset
REQ-029 While rst=1 the block SHALL set: state IDLE, mode 11, clr_sel 0000, pending 0, req_reg 11, frame counter 0, debounced levels 1111, debounce counters 0, synchronizer flops 1, vsync_d 0.
REQ-030 An rst asserted mid-operation (ARMED or ISSUE) SHALL discard the request and SHALL emit no clr_sel pulse.

Verification (DEBOUNCE_CYC=4, AUTO_FRAMES=3)
REQ-031 Bench SHALL hold key_n[3] low for 10 cycles, then pulse vsync -> pending=1 6 cycles after the fall; clr_sel=1000 for one cycle the cycle after the vsync edge; mode=01; pending=0.
REQ-032 Bench SHALL toggle key_n[2] low for 3 cycles only (glitch) -> no press, pending stays 0, no clr_sel pulse.
REQ-033 Bench SHALL press key1, then key0 before vsync -> a single pulse clr_sel=0001 and mode=11.
REQ-034 Bench SHALL drive auto_en=1 from reset with 7 vsync pulses -> pulses clr_sel=1000 at frame 3 and clr_sel=0100 at frame 6; mode goes 11 -> 01 -> 00.
REQ-035 Bench SHALL press key2 and assert vsync in the same cycle the press event occurs -> no pulse at that boundary; clr_sel=0100 at the next boundary.
REQ-036 Bench SHALL assert rst while ARMED with a key3 request, then apply vsync -> no pulse, mode=11, pending=0.
